// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and helpers.
//   SBOX      - forward S-box, 256 x 8
//   RCON      - round constants for rounds 1..10
//   xtime     - multiply by {02} in GF(2^8) mod x^8+x^4+x^3+x+1
//   sub_word  - S-box applied to each byte of a 32-bit word
//   rot_word  - cyclic left rotation of a word by one byte
//   rcon_for  - round constant for a round number, 0 outside 1..10
//   fsm_t     - controller state {IDLE, ROUND}
package aes_pkg;

  typedef enum logic {IDLE, ROUND} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // The counter also sits at 0 (after reset) and 11 (after a block) while
  // idle; those values must not index past the table.
  function automatic logic [7:0] rcon_for(input logic [3:0] round);
    logic [3:0] idx;
    idx = round - 4'd1;
    if (round >= 4'd1 && round <= 4'd10) return RCON[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// aes_round_datapath: one full AES-128 encryption round, purely combinational.
//   state      in  128  current state, byte 0 in [127:120], column-major
//   round_key  in  128  key used by the previous round
//   rcon       in  8    round constant for the round being computed
//   last       in  1    final round: MixColumns bypassed
//   next_state out 128  SubBytes, ShiftRows, (MixColumns), AddRoundKey
//   next_key   out 128  round key expanded from round_key and rcon
module aes_round_datapath
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

  // Byte index i = 4*column + row. ShiftRows moves row r left by r, so the
  // output byte at (row, col) comes from (row, (col + row) mod 4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sb[gi] = SBOX[state[127-8*gi -: 8]];
    assign sr[gi] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*gi];
    assign a1 = sr[4*gi+1];
    assign a2 = sr[4*gi+2];
    assign a3 = sr[4*gi+3];
    // {03}*x is computed as xtime(x) ^ x
    assign mc[4*gi]   = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    assign mc[4*gi+1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    assign mc[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    assign mc[4*gi+3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
  end

  // Key expansion: only w3 goes through RotWord/SubWord/Rcon, the rest chain.
  assign w0   = round_key[127:96];
  assign w1   = round_key[95:64];
  assign w2   = round_key[63:32];
  assign w3   = round_key[31:0];
  assign temp = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    next_state = '0;
    for (int i = 0; i < 16; i++) begin
      next_state[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes128_encrypt_core.sv
// aes128_encrypt_core: iterative AES-128 encryption, one round per clock.
//   clock              in  1    rising-edge clock
//   resetModule        in  1    synchronous active-high reset
//   inputData          in  128  plaintext, sampled only in the start cycle
//   key                in  128  cipher key, sampled only in the start cycle
//   inputsLoadedFlag   in  1    start request, honoured only in IDLE
//   outputData         out 128  ciphertext, held until next completion/reset
//   dataEncryptedFlag  out 1    one-cycle pulse when outputData updates
// A start at edge N runs rounds at edges N+1..N+10; the pulse follows N+10.
module aes128_encrypt_core
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         resetModule,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  input  logic         inputsLoadedFlag,
  output logic [127:0] outputData,
  output logic         dataEncryptedFlag
);

  fsm_t         fsm_reg;
  logic [3:0]   round_reg;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] state_next;
  logic [127:0] key_next;
  logic         last;

  assign last = (round_reg == 4'd10);

  aes_round_datapath u_round (
    .state      (state_reg),
    .round_key  (key_reg),
    .rcon       (rcon_for(round_reg)),
    .last       (last),
    .next_state (state_next),
    .next_key   (key_next)
  );

  always_ff @(posedge clock) begin
    if (resetModule) begin
      fsm_reg           <= IDLE;
      round_reg         <= 4'd0;
      state_reg         <= '0;
      key_reg           <= '0;
      outputData        <= '0;
      dataEncryptedFlag <= 1'b0;
    end else begin
      dataEncryptedFlag <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (inputsLoadedFlag) begin
            state_reg <= inputData ^ key;
            key_reg   <= key;
            round_reg <= 4'd1;
            fsm_reg   <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= state_next;
          key_reg   <= key_next;
          round_reg <= round_reg + 4'd1;
          if (last) begin
            outputData        <= state_next;
            dataEncryptedFlag <= 1'b1;
            fsm_reg           <= IDLE;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// tb_aes128_encrypt_core: checks aes128_encrypt_core against FIPS-197 vectors
// and against a textbook AES-128 model (S-box derived from the GF(2^8)
// inverse plus affine map, full key schedule, matrix MixColumns).
module tb_aes128_encrypt_core;

  logic         clock = 1'b0;
  logic         resetModule;
  logic [127:0] inputData;
  logic [127:0] key;
  logic         inputsLoadedFlag;
  logic [127:0] outputData;
  logic         dataEncryptedFlag;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] sbox_ref [256];

  localparam logic [127:0] C1_DATA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_OUT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_DATA  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_OUT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Z_OUT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clock = ~clock;

  aes128_encrypt_core dut (
    .clock             (clock),
    .resetModule       (resetModule),
    .inputData         (inputData),
    .key               (key),
    .inputsLoadedFlag  (inputsLoadedFlag),
    .outputData        (outputData),
    .dataEncryptedFlag (dataEncryptedFlag)
  );

  task automatic check_value(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product then reduction modulo 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (prod[i]) prod ^= 15'h11b << (i - 8);
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));  // x^254 = x^-1
      end
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   coef [4];
    logic [7:0]   rc;
    logic [127:0] rk, res;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    rk = {w[0], w[1], w[2], w[3]};
    for (int j = 0; j < 16; j++) st[j] = pt[127-8*j -: 8] ^ rk[127-8*j -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) tmp[j] = sbox_ref[st[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) st[4*c+row] = tmp[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int j = 0; j < 16; j++) tmp[j] = st[j];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            st[4*c+row] = 8'h00;
            for (int m = 0; m < 4; m++)
              st[4*c+row] ^= gmul(coef[(m - row + 4) % 4], tmp[4*c+m]);
          end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int j = 0; j < 16; j++) st[j] ^= rk[127-8*j -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = st[j];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the negedge after the start edge N.
  task automatic start_block(input logic [127:0] d, input logic [127:0] k);
    inputData        = d;
    key              = k;
    inputsLoadedFlag = 1'b1;
    @(negedge clock);
    inputsLoadedFlag = 1'b0;
  endtask

  // 'seen' = edges after N already elapsed. The flag must first appear
  // after edge N+10, i.e. in the eleventh cycle counting the start cycle.
  task automatic wait_done(input string tag, input logic [127:0] expected, input int seen);
    int n;
    n = seen;
    do begin
      @(negedge clock);
      n++;
    end while (!dataEncryptedFlag && n < 25);
    check_value({tag, " latency"}, 128'(n), 128'(10));
    check_value({tag, " data"}, outputData, expected);
    $display("block %s: out=%h flag after %0d edges", tag, outputData, n);
  endtask

  task automatic expect_no_flag(input string tag, input int cycles);
    int flags;
    flags = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (dataEncryptedFlag) flags++;
    end
    check_value({tag, " flags"}, 128'(flags), 128'(0));
    $display("idle window %s: %0d flags in %0d cycles", tag, flags, cycles);
  endtask

  initial begin
    logic [127:0] d, k;
    build_sbox();
    resetModule      = 1'b1;
    inputsLoadedFlag = 1'b0;
    inputData        = '0;
    key              = '0;
    repeat (3) @(negedge clock);
    check_value("reset outputData", outputData, 128'h0);
    check_value("reset flag", 128'(dataEncryptedFlag), 128'h0);
    check_value("reset round", 128'(dut.round_reg), 128'h0);
    resetModule = 1'b0;

    // FIPS-197 C.1
    start_block(C1_DATA, C1_KEY);
    wait_done("fips_c1", C1_OUT, 0);
    @(negedge clock);
    check_value("c1 pulse width", 128'(dataEncryptedFlag), 128'h0);

    // FIPS-197 App. B with round-1 key probe
    start_block(B_DATA, B_KEY);
    @(negedge clock);
    check_value("appB round1 key", dut.key_reg, B_RK1);
    wait_done("fips_b", B_OUT, 1);

    // All-zero, back to back: second start at the flag cycle (edge N+11)
    start_block(128'h0, 128'h0);
    wait_done("zero_a", Z_OUT, 0);
    start_block(128'h0, 128'h0);
    check_value("zero pulse width", 128'(dataEncryptedFlag), 128'h0);
    wait_done("zero_b", Z_OUT, 0);

    // Inputs and start disturbed while a block is in flight
    start_block(C1_DATA, C1_KEY);
    for (int i = 1; i <= 4; i++) begin
      inputData        = rand128();
      key              = rand128();
      inputsLoadedFlag = (i % 2 == 1);
      @(negedge clock);
      check_value("midop early flag", 128'(dataEncryptedFlag), 128'h0);
    end
    inputsLoadedFlag = 1'b0;
    wait_done("midop", C1_OUT, 4);

    // Reset during round 5 aborts silently
    start_block(B_DATA, B_KEY);
    repeat (4) @(negedge clock);
    resetModule = 1'b1;
    @(negedge clock);
    resetModule = 1'b0;
    check_value("abort outputData", outputData, 128'h0);
    check_value("abort round", 128'(dut.round_reg), 128'h0);
    expect_no_flag("after_abort", 15);
    d = rand128();
    k = rand128();
    start_block(d, k);
    wait_done("post_abort", aes_ref(d, k), 0);

    // Reset together with start in IDLE wins
    inputData        = C1_DATA;
    key              = C1_KEY;
    resetModule      = 1'b1;
    inputsLoadedFlag = 1'b1;
    @(negedge clock);
    resetModule      = 1'b0;
    inputsLoadedFlag = 1'b0;
    check_value("rst+start round", 128'(dut.round_reg), 128'h0);
    expect_no_flag("rst_start", 15);
    check_value("rst+start outputData", outputData, 128'h0);

    // Randomized blocks against the model
    for (int t = 0; t < 8; t++) begin
      d = rand128();
      k = rand128();
      start_block(d, k);
      wait_done($sformatf("rand%0d", t), aes_ref(d, k), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
